wb_bec_responder: RTL
=====================

Name: wb_bec_responder

Overview:
- Wishbone classic slave (responder) on the Caravel management bus: wbs_* from the SoC initiator in, wbs_ack_o/wbs_dat_o back.
- Exposes a small register map. Firmware uses it to feed 32-bit words to a downstream crypto core through a FIFO with a valid/ready handshake.
- Captures the core's result words and done events, and raises user_irq.
- Sits in user_project_wrapper between the wbs_* pins and the core's data bus.

Parameters:
- BASE_ADDR, 32'h3000_0000, slave base; decode matches wbs_adr_i[31:8] == BASE_ADDR[31:8].
- FIFO_DEPTH, 4, TX word FIFO entries; must be a power of 2, ≥2.
- CW, 3, count width = log2(FIFO_DEPTH)+1.

Ports:
- wb_clk_i  in  1  single clock for all logic.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- wbs_stb_i  in  1  strobe.
- wbs_cyc_i  in  1  cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- core_en_o  out  1  CTRL.enable to core.
- core_data_o  out  32  FIFO head word.
- core_valid_o  out  1  head word valid.
- core_ready_i  in  1  core accepts head word.
- res_valid_i  in  1  one-cycle result strobe.
- res_data_i  in  32  result word.
- done_i  in  1  one-cycle core done pulse.
- irq_o  out  1  level interrupt.

Behaviour:
- Reset (async, wb_rst_ni=0): all outputs 0, FIFO empty, all registers 0. Takes effect immediately; an in-flight ack is dropped and the initiator must retry.
- Bus FSM states:
  - IDLE: on stb&cyc&addr_hit → ACK, performing the access this same edge.
  - ACK: wbs_ack_o=1 for exactly one cycle, then → IDLE.
  - Each access takes 2 cycles; no back-to-back acks.
  - Addresses that miss BASE are never acked.
- Register map, word offset wbs_adr_i[4:2]:
  - 0 CTRL (RW): bit0 enable, bit1 fifo_clr (self-clears next cycle), bit2 rx_clr (self-clears). Byte lane 0 only, gated by sel[0].
  - 1 STATUS (RO, W1C): bit0 rx_valid, bit1 done_sticky (W1C), bit2 overflow (W1C), bit3 fifo_full, bit4 fifo_empty, bits[CW+7:8] fifo_count.
  - 2 TXDATA (WO): full-word push into FIFO; sel ignored. Reads return 0.
  - 3 RXDATA (RO): last captured result. A read clears rx_valid.
  - 4 IRQ_EN (RW): bit0 done, bit1 overflow, bit2 rx_valid. Gated by sel[0].
  - 5–7: read 0, writes ignored, still acked.
- FIFO:
  - core_valid_o = enable & !empty; core_data_o = head word.
  - Pop on core_valid_o & core_ready_i.
  - Push when full: data dropped, overflow set, ack still returned. Exception: a push and pop in the same cycle while full succeeds (count unchanged).
  - fifo_clr empties the FIFO the same cycle the write is performed. If a pop coincides, clr wins.
  - Pointers wrap modulo FIFO_DEPTH.
  - enable=0 freezes output, contents kept.
- Result capture:
  - res_valid_i latches res_data_i and sets rx_valid.
  - A new result overwrites an unread one (no overflow flag).
  - A capture in the same cycle as an RXDATA read leaves rx_valid=1 with the new data.
- Sticky bits:
  - done_sticky set by done_i; overflow set as above.
  - Same-cycle set and W1C: set wins.
- irq_o: registered OR of (IRQ_EN bit & status bit) for done, overflow, rx_valid. One cycle latency from the flag.

Test Plan:
- Reset: assert wb_rst_ni=0 mid-ACK → wbs_ack_o drops at once; after release, STATUS read = 32'h0000_0010 (empty).
- FIFO feed: write CTRL=1, write TXDATA 0xA5A5_0001..0xA5A5_0003 with core_ready_i=0 → STATUS count=3. Raise ready → core_data_o presents the three words in order, one per cycle; then core_valid_o=0.
- Overflow: with ready=0, push 5 words → STATUS bit2=1, count=4, fifth word absent. Write STATUS=32'h4 → bit2 clears.
- Full + simultaneous pop: FIFO full, ready=1, push 0xDEAD_BEEF → accepted, no overflow, count stays 4.
- Result/IRQ: IRQ_EN=1, pulse done_i → irq_o=1 two edges later. Pulse res_valid_i with 0x1234_5678 → RXDATA read returns 0x1234_5678 and rx_valid clears. W1C done → irq_o=0.
- Decode: access at BASE+0x1C → read 0, acked. Access at 0x3000_1000 → never acked. Every acked access has ack high for exactly 1 cycle.

Source files
------------

// File: rtl/wb_bec_responder.sv
// wb_bec_fifo: small generic word FIFO with synchronous clear and full-with-pop push acceptance.
// Latency: a pushed word is visible at head_dat_o the cycle after the push edge.
// Backpressure: push_rdy_o is low when full, unless a pop happens in the same cycle.
module wb_bec_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    parameter int CW    = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          push_vld_i,
    input  logic [W-1:0]  push_dat_i,
    output logic          push_rdy_o,
    input  logic          pop_i,
    output logic [W-1:0]  head_dat_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];
    assign do_pop     = pop_i & ~empty_o;
    assign push_rdy_o = ~full_o | do_pop;
    assign do_push    = push_vld_i & push_rdy_o;

    // Storage, pointers (wrap naturally at DEPTH) and occupancy; clear beats any pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (!do_push && do_pop) count_q <= count_q - CW'(1);
        end
    end
endmodule

// wb_bec_responder: Wishbone classic register slave feeding TX words to a crypto core and capturing its results/done.
// Latency: each hit access is performed on the strobe edge and acked for one cycle after it; irq_o lags its flag by one cycle.
// Backpressure: core_ready_i holds the FIFO head; a push into a full FIFO is dropped and flagged, the bus never stalls.
module wb_bec_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          CW         = 3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        core_en_o,
    output logic [31:0] core_data_o,
    output logic        core_valid_o,
    input  logic        core_ready_i,
    input  logic        res_valid_i,
    input  logic [31:0] res_data_i,
    input  logic        done_i,
    output logic        irq_o
);
    typedef enum logic {S_IDLE, S_ACK} state_t;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_TXDATA = 3'd2;
    localparam logic [2:0] REG_RXDATA = 3'd3;
    localparam logic [2:0] REG_IRQ_EN = 3'd4;

    state_t        state_q;
    logic          ack_q;
    logic [31:0]   dat_q;
    logic          en_q, fifo_clr_q, rx_clr_q;
    logic          rx_vld_q;
    logic [31:0]   rx_dat_q;
    logic          done_q, ovf_q, irq_q;
    logic          done_d, ovf_d, irq_d;
    logic [2:0]    irq_en_q;

    logic          addr_hit, acc, wr, rd;
    logic [2:0]    reg_sel;
    logic          wr_ctrl, wr_stat, wr_tx, wr_irq_en, rd_rx;
    logic          fifo_clr, rx_clr, fifo_pop, ovf_set;
    logic          fifo_push_rdy, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status, rdata_d;
    logic          unused_bits;

    // Address bits below the word offset and upper byte lanes play no part in decode.
    assign unused_bits = ^{wbs_adr_i[7:5], wbs_adr_i[1:0], wbs_sel_i[3:1]};

    assign addr_hit  = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign acc       = (state_q == S_IDLE) & wbs_stb_i & wbs_cyc_i & addr_hit;
    assign wr        = acc & wbs_we_i;
    assign rd        = acc & ~wbs_we_i;
    assign reg_sel   = wbs_adr_i[4:2];
    assign wr_ctrl   = wr & (reg_sel == REG_CTRL) & wbs_sel_i[0];
    assign wr_stat   = wr & (reg_sel == REG_STATUS);
    assign wr_tx     = wr & (reg_sel == REG_TXDATA);
    assign wr_irq_en = wr & (reg_sel == REG_IRQ_EN) & wbs_sel_i[0];
    assign rd_rx     = rd & (reg_sel == REG_RXDATA);
    assign fifo_clr  = wr_ctrl & wbs_dat_i[1];
    assign rx_clr    = wr_ctrl & wbs_dat_i[2];

    assign core_en_o    = en_q;
    assign core_valid_o = en_q & ~fifo_empty;
    assign fifo_pop     = core_valid_o & core_ready_i;
    assign ovf_set      = wr_tx & ~fifo_push_rdy;
    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign irq_o        = irq_q;

    wb_bec_fifo #(.DEPTH(FIFO_DEPTH), .W(32), .CW(CW)) u_tx_fifo (
        .clk_i      (wb_clk_i),
        .rst_ni     (wb_rst_ni),
        .clr_i      (fifo_clr),
        .push_vld_i (wr_tx),
        .push_dat_i (wbs_dat_i),
        .push_rdy_o (fifo_push_rdy),
        .pop_i      (fifo_pop),
        .head_dat_o (core_data_o),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Status word, read mux, and next-state of sticky flags (set beats W1C) and interrupt.
    always_comb begin
        status            = '0;
        status[0]         = rx_vld_q;
        status[1]         = done_q;
        status[2]         = ovf_q;
        status[3]         = fifo_full;
        status[4]         = fifo_empty;
        status[CW+7:8]    = fifo_count;
        rdata_d           = '0;
        case (reg_sel)
            REG_CTRL:   rdata_d[2:0] = {rx_clr_q, fifo_clr_q, en_q};
            REG_STATUS: rdata_d      = status;
            REG_RXDATA: rdata_d      = rx_dat_q;
            REG_IRQ_EN: rdata_d[2:0] = irq_en_q;
            default:    rdata_d      = '0;
        endcase
        done_d = done_i  | (done_q & ~(wr_stat & wbs_dat_i[1]));
        ovf_d  = ovf_set | (ovf_q  & ~(wr_stat & wbs_dat_i[2]));
        irq_d  = |(irq_en_q & {rx_vld_q, ovf_q, done_q});
    end

    // Bus FSM: perform the access on the strobe edge, then hold ack and read data for one cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (acc) begin
                    state_q <= S_ACK;
                    ack_q   <= 1'b1;
                    dat_q   <= wbs_we_i ? '0 : rdata_d;
                end
                default: begin
                    state_q <= S_IDLE;
                    ack_q   <= 1'b0;
                    dat_q   <= '0;
                end
            endcase
        end
    end

    // CTRL and IRQ_EN registers; the clear strobes read back for one cycle only.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            en_q       <= 1'b0;
            fifo_clr_q <= 1'b0;
            rx_clr_q   <= 1'b0;
            irq_en_q   <= '0;
        end else begin
            fifo_clr_q <= 1'b0;
            rx_clr_q   <= 1'b0;
            if (wr_ctrl) begin
                en_q       <= wbs_dat_i[0];
                fifo_clr_q <= wbs_dat_i[1];
                rx_clr_q   <= wbs_dat_i[2];
            end
            if (wr_irq_en) irq_en_q <= wbs_dat_i[2:0];
        end
    end

    // Result capture: a new result beats a same-cycle RXDATA read or rx clear.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rx_vld_q <= 1'b0;
            rx_dat_q <= '0;
        end else if (res_valid_i) begin
            rx_vld_q <= 1'b1;
            rx_dat_q <= res_data_i;
        end else if (rd_rx || rx_clr) begin
            rx_vld_q <= 1'b0;
        end
    end

    // Sticky flags and the registered interrupt level.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            done_q <= done_d;
            ovf_q  <= ovf_d;
            irq_q  <= irq_d;
        end
    end
endmodule
